// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states, mux selects,
// ALU op codes and the opcode/funct values the decoder recognises.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_FETCH       = 5'd0,
        S_FETCH_LATCH = 5'd1,
        S_DECODE      = 5'd2,
        S_EXEC_R      = 5'd3,
        S_EXEC_ADDI   = 5'd4,
        S_WB_R        = 5'd5,
        S_WB_I        = 5'd6,
        S_BRANCH      = 5'd7,
        S_JUMP        = 5'd8,
        S_MEM_ADDR    = 5'd9,
        S_MEM_RD      = 5'd10,
        S_MDR_LATCH   = 5'd11,
        S_MEM_WR      = 5'd12,
        S_WB_LW       = 5'd13,
        S_TRAP        = 5'd14
    } state_t;

    localparam logic [1:0] ULA_A_BRANCH = 2'b00;
    localparam logic [1:0] ULA_A_REGA   = 2'b01;
    localparam logic [1:0] ULA_A_MEM    = 2'b10;
    localparam logic [1:0] ULA_A_FOUR   = 2'b11;

    localparam logic [1:0] ULA_B_PC     = 2'b00;
    localparam logic [1:0] ULA_B_REGB   = 2'b01;
    localparam logic [1:0] ULA_B_IMM    = 2'b10;

    localparam logic [2:0] ULA_PASS_A   = 3'b000;
    localparam logic [2:0] ULA_ADD      = 3'b001;
    localparam logic [2:0] ULA_SUB      = 3'b010;
    localparam logic [2:0] ULA_AND      = 3'b011;
    localparam logic [2:0] ULA_OR       = 3'b100;
    localparam logic [2:0] ULA_SLT      = 3'b101;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_OVF     = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic r_funct_legal(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic logic [2:0] r_funct_op(input logic [5:0] funct);
        logic [2:0] op;
        case (funct)
            FN_ADD:  op = ULA_ADD;
            FN_SUB:  op = ULA_SUB;
            FN_AND:  op = ULA_AND;
            FN_OR:   op = ULA_OR;
            FN_SLT:  op = ULA_SLT;
            default: op = ULA_PASS_A;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mc_control_unit.sv
// Multicycle Moore control FSM for the MIPS-subset datapath; sequences fetch, decode,
// execute, memory and writeback, and halts in a sticky trap on overflow or illegal code.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// FETCH        | instruction memory read at PC, held MEM_WAIT_CYCLES cycles
// FETCH_LATCH  | load IR, PC <= PC + 4
// DECODE       | load A/B, ALUOut <= branch target, dispatch on opcode/funct
// EXEC_R       | R-type ALU op into ALUOut, overflow check for add/sub
// EXEC_ADDI    | reg A + imm into ALUOut, overflow check
// WB_R / WB_I  | recompute result and write to rd / rt
// BRANCH       | compare A-B, PC <= ALUOut when condition holds
// JUMP         | PC <= jump target
// MEM_ADDR     | effective address into ALUOut
// MEM_RD       | data memory read at ALUOut, MEM_WAIT_CYCLES cycles
// MDR_LATCH    | capture read data in MDR
// MEM_WR       | data memory write at ALUOut, MEM_WAIT_CYCLES cycles
// WB_LW        | pass MDR through ALU into rt
// TRAP         | halted until reset
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [1:0] ula_a_sel,
    output logic [1:0] ula_b_sel,
    output logic [2:0] ula_op,
    output logic [1:0] pc_src_sel,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_addr_sel,
    output logic       mem_wr,
    output logic       mdr_write,
    output logic       a_write,
    output logic       aluout_write,
    output logic       reg_dst_sel,
    output logic       reg_write,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [4:0] state_dbg
);

    localparam int CNT_W = (MEM_WAIT_CYCLES < 2) ? 1 : $clog2(MEM_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;
    logic [1:0]       cause_q, cause_nxt;
    logic             wait_done;

    assign wait_done  = (wait_cnt == WAIT_LAST);
    assign state_dbg  = state;
    assign trap_cause = cause_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            cause_q  <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_nxt     = '0;
        cause_nxt    = cause_q;
        ula_a_sel    = ULA_A_BRANCH;
        ula_b_sel    = ULA_B_PC;
        ula_op       = ULA_PASS_A;
        pc_src_sel   = PC_SRC_ALU;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_addr_sel = 1'b0;
        mem_wr       = 1'b0;
        mdr_write    = 1'b0;
        a_write      = 1'b0;
        aluout_write = 1'b0;
        reg_dst_sel  = 1'b0;
        reg_write    = 1'b0;
        trap         = 1'b0;

        case (state)
            S_FETCH: begin
                if (wait_done) state_nxt = S_FETCH_LATCH;
                else           wait_nxt  = wait_cnt + 1'b1;
            end
            S_FETCH_LATCH: begin
                ir_write  = 1'b1;
                ula_a_sel = ULA_A_FOUR;
                ula_b_sel = ULA_B_PC;
                ula_op    = ULA_ADD;
                pc_write  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                a_write      = 1'b1;
                ula_op       = ULA_ADD;
                aluout_write = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (r_funct_legal(funct)) begin
                            state_nxt = S_EXEC_R;
                        end else begin
                            state_nxt = S_TRAP;
                            cause_nxt = CAUSE_ILLEGAL;
                        end
                    end
                    OP_ADDI:       state_nxt = S_EXEC_ADDI;
                    OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                    OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
                    OP_J:          state_nxt = S_JUMP;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                ula_a_sel    = ULA_A_REGA;
                ula_b_sel    = ULA_B_REGB;
                ula_op       = r_funct_op(funct);
                aluout_write = 1'b1;
                // only the signed arithmetic ops can overflow; logic/slt ignore the flag
                if (overflow && (funct == FN_ADD || funct == FN_SUB)) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_OVF;
                end else begin
                    state_nxt = S_WB_R;
                end
            end
            S_EXEC_ADDI: begin
                ula_a_sel    = ULA_A_REGA;
                ula_b_sel    = ULA_B_IMM;
                ula_op       = ULA_ADD;
                aluout_write = 1'b1;
                if (overflow) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_OVF;
                end else begin
                    state_nxt = S_WB_I;
                end
            end
            S_WB_R: begin
                ula_a_sel   = ULA_A_REGA;
                ula_b_sel   = ULA_B_REGB;
                ula_op      = r_funct_op(funct);
                reg_write   = 1'b1;
                reg_dst_sel = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_WB_I: begin
                ula_a_sel = ULA_A_REGA;
                ula_b_sel = ULA_B_IMM;
                ula_op    = ULA_ADD;
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ula_a_sel  = ULA_A_REGA;
                ula_b_sel  = ULA_B_REGB;
                ula_op     = ULA_SUB;
                pc_src_sel = PC_SRC_ALUOUT;
                pc_write   = (opcode == OP_BEQ) ? zero : !zero;
                state_nxt  = S_FETCH;
            end
            S_JUMP: begin
                pc_src_sel = PC_SRC_JUMP;
                pc_write   = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ula_a_sel    = ULA_A_REGA;
                ula_b_sel    = ULA_B_IMM;
                ula_op       = ULA_ADD;
                aluout_write = 1'b1;
                state_nxt    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_addr_sel = 1'b1;
                if (wait_done) state_nxt = S_MDR_LATCH;
                else           wait_nxt  = wait_cnt + 1'b1;
            end
            S_MDR_LATCH: begin
                mdr_write = 1'b1;
                state_nxt = S_WB_LW;
            end
            S_MEM_WR: begin
                mem_addr_sel = 1'b1;
                mem_wr       = 1'b1;
                if (wait_done) state_nxt = S_FETCH;
                else           wait_nxt  = wait_cnt + 1'b1;
            end
            S_WB_LW: begin
                ula_a_sel = ULA_A_MEM;
                ula_op    = ULA_PASS_A;
                reg_write = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomised self-checking bench: each instruction is expanded into its expected
// per-cycle control vector sequence and compared against two DUTs (N=1 and N=3).
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] op;
        logic [1:0] pcs;
        logic       pcw;
        logic       irw;
        logic       mas;
        logic       mwr;
        logic       mdr;
        logic       aw;
        logic       aow;
        logic       rdst;
        logic       rw;
        logic       trap;
        logic [1:0] cause;
        logic [4:0] st;
    } ctl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero, overflow;

    logic [1:0] a1, b1, pcs1, cause1, a3, b3, pcs3, cause3;
    logic [2:0] op1, op3;
    logic [4:0] st1, st3;
    logic pcw1, irw1, mas1, mwr1, mdr1, aw1, aow1, rdst1, rw1, trap1;
    logic pcw3, irw3, mas3, mwr3, mdr3, aw3, aow3, rdst3, rw3, trap3;

    mc_control_unit #(.MEM_WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .ula_a_sel(a1), .ula_b_sel(b1), .ula_op(op1), .pc_src_sel(pcs1), .pc_write(pcw1),
        .ir_write(irw1), .mem_addr_sel(mas1), .mem_wr(mwr1), .mdr_write(mdr1), .a_write(aw1),
        .aluout_write(aow1), .reg_dst_sel(rdst1), .reg_write(rw1), .trap(trap1),
        .trap_cause(cause1), .state_dbg(st1)
    );

    mc_control_unit #(.MEM_WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
        .ula_a_sel(a3), .ula_b_sel(b3), .ula_op(op3), .pc_src_sel(pcs3), .pc_write(pcw3),
        .ir_write(irw3), .mem_addr_sel(mas3), .mem_wr(mwr3), .mdr_write(mdr3), .a_write(aw3),
        .aluout_write(aow3), .reg_dst_sel(rdst3), .reg_write(rw3), .trap(trap3),
        .trap_cause(cause3), .state_dbg(st3)
    );

    int checks = 0;
    int errors = 0;
    ctl_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed(input int n);
        if (n == 1)
            return {a1, b1, op1, pcs1, pcw1, irw1, mas1, mwr1, mdr1, aw1, aow1, rdst1, rw1, trap1, cause1, st1};
        return {a3, b3, op3, pcs3, pcw3, irw3, mas3, mwr3, mdr3, aw3, aow3, rdst3, rw3, trap3, cause3, st3};
    endfunction

    function automatic ctl_t mk(input state_t s, input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] op, input logic [1:0] pcs);
        ctl_t c = '0;
        c.st = s; c.a = a; c.b = b; c.op = op; c.pcs = pcs;
        return c;
    endfunction

    // R-type funct -> ALU op; 3'b111 marks an unsupported funct
    function automatic logic [2:0] model_rop(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'b001;
            6'h22: return 3'b010;
            6'h24: return 3'b011;
            6'h25: return 3'b100;
            6'h2A: return 3'b101;
            default: return 3'b111;
        endcase
    endfunction

    // Expands one instruction into its cycle-by-cycle expected control vectors.
    task automatic build(input int n, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic ov, output bit traps);
        ctl_t c;
        logic [1:0] cause = 2'b00;
        exp_q.delete();
        traps = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(mk(S_FETCH, 2'b00, 2'b00, 3'b000, 2'b00));
        c = mk(S_FETCH_LATCH, 2'b11, 2'b00, 3'b001, 2'b00); c.irw = 1; c.pcw = 1; exp_q.push_back(c);
        c = mk(S_DECODE, 2'b00, 2'b00, 3'b001, 2'b00); c.aw = 1; c.aow = 1; exp_q.push_back(c);
        if (op == 6'h00 && model_rop(fn) != 3'b111) begin
            c = mk(S_EXEC_R, 2'b01, 2'b01, model_rop(fn), 2'b00); c.aow = 1; exp_q.push_back(c);
            if (ov && (fn == 6'h20 || fn == 6'h22)) begin traps = 1; cause = 2'b01; end
            else begin
                c = mk(S_WB_R, 2'b01, 2'b01, model_rop(fn), 2'b00); c.rw = 1; c.rdst = 1; exp_q.push_back(c);
            end
        end else if (op == 6'h08) begin
            c = mk(S_EXEC_ADDI, 2'b01, 2'b10, 3'b001, 2'b00); c.aow = 1; exp_q.push_back(c);
            if (ov) begin traps = 1; cause = 2'b01; end
            else begin
                c = mk(S_WB_I, 2'b01, 2'b10, 3'b001, 2'b00); c.rw = 1; exp_q.push_back(c);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            c = mk(S_BRANCH, 2'b01, 2'b01, 3'b010, 2'b01); c.pcw = (op == 6'h04) ? z : ~z; exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c = mk(S_JUMP, 2'b00, 2'b00, 3'b000, 2'b10); c.pcw = 1; exp_q.push_back(c);
        end else if (op == 6'h23 || op == 6'h2B) begin
            c = mk(S_MEM_ADDR, 2'b01, 2'b10, 3'b001, 2'b00); c.aow = 1; exp_q.push_back(c);
            for (int i = 0; i < n; i++) begin
                c = mk((op == 6'h23) ? S_MEM_RD : S_MEM_WR, 2'b00, 2'b00, 3'b000, 2'b00);
                c.mas = 1; c.mwr = (op == 6'h2B); exp_q.push_back(c);
            end
            if (op == 6'h23) begin
                c = mk(S_MDR_LATCH, 2'b00, 2'b00, 3'b000, 2'b00); c.mdr = 1; exp_q.push_back(c);
                c = mk(S_WB_LW, 2'b10, 2'b00, 3'b000, 2'b00); c.rw = 1; exp_q.push_back(c);
            end
        end else begin
            traps = 1; cause = 2'b10;
        end
        if (traps) begin
            for (int i = 0; i < 3; i++) begin
                c = mk(S_TRAP, 2'b00, 2'b00, 3'b000, 2'b00); c.trap = 1; c.cause = cause; exp_q.push_back(c);
            end
        end else begin
            exp_q.push_back(mk(S_FETCH, 2'b00, 2'b00, 3'b000, 2'b00));
        end
    endtask

    // Resets both DUTs, then steps one instruction; abort_at >= 0 reasserts reset at that cycle.
    task automatic run_instr(input string tag, input int n, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic ov, input int abort_at);
        bit traps;
        build(n, op, fn, z, ov, traps);
        reset = 1'b1;
        opcode = op; funct = fn; zero = z; overflow = ov;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s n%0d cyc%0d", tag, n, i), 32'(observed(n)), 32'(exp_q[i]));
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                check_eq($sformatf("%s rst_vec", tag), 32'(observed(n)),
                         32'(mk(S_FETCH, 2'b00, 2'b00, 3'b000, 2'b00)));
                check_eq($sformatf("%s rst_mem_wr", tag), 32'(n == 1 ? mwr1 : mwr3), 32'd0);
                check_eq($sformatf("%s rst_trap", tag), 32'(n == 1 ? trap1 : trap3), 32'd0);
                reset = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    function automatic bit legal_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
    endfunction

    initial begin
        logic [5:0] rfn [5];
        logic [5:0] lops [6];
        logic [5:0] op, fn;
        int k, n;
        rfn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        lops = '{6'h08, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h02};
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_instr("add",        1, 6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr("sub_ovf",    3, 6'h00, 6'h22, 1'b0, 1'b1, -1);
        run_instr("and_ovf",    1, 6'h00, 6'h24, 1'b0, 1'b1, -1);
        run_instr("beq_taken",  1, 6'h04, 6'h00, 1'b1, 1'b0, -1);
        run_instr("beq_not",    1, 6'h04, 6'h00, 1'b0, 1'b0, -1);
        run_instr("bne_taken",  3, 6'h05, 6'h00, 1'b0, 1'b0, -1);
        run_instr("bne_not",    3, 6'h05, 6'h00, 1'b1, 1'b0, -1);
        run_instr("lw",         3, 6'h23, 6'h00, 1'b0, 1'b0, -1);
        run_instr("sw",         1, 6'h2B, 6'h00, 1'b0, 1'b0, -1);
        run_instr("j",          1, 6'h02, 6'h00, 1'b0, 1'b0, -1);
        run_instr("addi_ovf",   1, 6'h08, 6'h00, 1'b0, 1'b1, -1);
        run_instr("addi",       3, 6'h08, 6'h00, 1'b0, 1'b0, -1);
        run_instr("ill_op",     1, 6'h3F, 6'h20, 1'b0, 1'b0, -1);
        run_instr("ill_funct",  3, 6'h00, 6'h03, 1'b0, 1'b0, -1);
        // index 7 is the second MEM_WR cycle with N=3 (3 fetch + latch + decode + addr + 1)
        run_instr("rst_mid_sw", 3, 6'h2B, 6'h00, 1'b0, 1'b0, 7);

        for (int it = 0; it < 80; it++) begin
            k  = $urandom_range(0, 7);
            n  = ($urandom_range(0, 1) == 1) ? 3 : 1;
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
                1, 2, 3: op = lops[$urandom_range(0, 5)];
                4: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
                5: begin
                    op = 6'($urandom_range(0, 63));
                    while (legal_op(op)) op = 6'($urandom_range(0, 63));
                end
                6: begin
                    op = 6'h00;
                    while (model_rop(fn) != 3'b111) fn = 6'($urandom_range(0, 63));
                end
                default: op = lops[$urandom_range(0, 5)];
            endcase
            run_instr($sformatf("rnd%0d", it), n, op, fn, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
